rgb_pixel_proc_pipe: RTL

- Pixel-processing stage between the multi-pixel image reader and the image writer.
- Consumes NUM_OF_PIXEL parallel RGB pixels per HSYNC-qualified beat.
- Applies a frame-stable operation to every pixel (bypass, grayscale, brightness add/subtract, or threshold) in a fixed 3-stage pipeline.
- Emits the processed beat with a delayed HSYNC, and pulses frame_done on the last beat of each frame.

---
 rtl/rgb_pixel_proc_pipe.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/rgb_pixel_proc_pipe.sv
// Per-pixel RGB processing stage: bypass, grayscale, brightness or threshold applied to
// NUM_OF_PIXEL pixels per HSYNC beat, with frame-level control shadowing and frame_done.
module rgb_pixel_proc_pipe #(
    parameter int unsigned NUM_OF_PIXEL = 8,
    parameter int unsigned WIDTH        = 768,
    parameter int unsigned HEIGHT       = 512
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      HSYNC_IN,
    input  logic [8*NUM_OF_PIXEL-1:0] DATA_R_IN,
    input  logic [8*NUM_OF_PIXEL-1:0] DATA_G_IN,
    input  logic [8*NUM_OF_PIXEL-1:0] DATA_B_IN,
    input  logic [1:0]                MODE,
    input  logic [7:0]                VALUE,
    input  logic                      SIGN,
    output logic                      HSYNC_OUT,
    output logic [8*NUM_OF_PIXEL-1:0] DATA_R_OUT,
    output logic [8*NUM_OF_PIXEL-1:0] DATA_G_OUT,
    output logic [8*NUM_OF_PIXEL-1:0] DATA_B_OUT,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      overrun
);

    localparam int unsigned DW    = 8 * NUM_OF_PIXEL;
    localparam int unsigned BEATS = WIDTH * HEIGHT / NUM_OF_PIXEL;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS + 1) : 1;

    typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      drain_q, drain_d;
    logic [1:0]      mode_q;
    logic [7:0]      value_q;
    logic            sign_q;
    logic            accept, last_beat;

    assign accept    = HSYNC_IN && (state_q != StDrain);
    assign last_beat = (cnt_q == CW'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        case (state_q)
            StIdle, StActive: begin
                if (HSYNC_IN) begin
                    if (last_beat) begin
                        state_d = StDrain;
                        cnt_d   = '0;
                        drain_d = 2'd0;
                    end else begin
                        state_d = StActive;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (drain_q == 2'd2) begin
                    state_d = StIdle;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            drain_q <= 2'd0;
            mode_q  <= 2'd0;
            value_q <= 8'd0;
            sign_q  <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            // Control tracks the inputs only between frames.
            if (state_q == StIdle) begin
                mode_q  <= MODE;
                value_q <= VALUE;
                sign_q  <= SIGN;
            end
            // Registered from the current state so busy falls one cycle after frame_done.
            busy <= (state_q != StIdle);
            if (HSYNC_IN && (state_q == StDrain)) begin
                overrun <= 1'b1;
            end
        end
    end

    logic          in_v_q, in_last_q, s1_v_q, s1_last_q, s2_v_q, s2_last_q;
    logic [DW-1:0] in_r_q, in_g_q, in_b_q;
    logic [DW-1:0] s1_r_q, s1_g_q, s1_b_q;
    logic [DW-1:0] s2_r_q, s2_g_q, s2_b_q;
    logic [15:0]   pr_q [NUM_OF_PIXEL];
    logic [15:0]   pg_q [NUM_OF_PIXEL];
    logic [15:0]   pb_q [NUM_OF_PIXEL];
    logic [17:0]   sum_d [NUM_OF_PIXEL];
    logic [7:0]    gray_d [NUM_OF_PIXEL];
    logic [7:0]    gray_q [NUM_OF_PIXEL];
    logic [DW-1:0] res_r, res_g, res_b;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            in_v_q    <= 1'b0;
            in_last_q <= 1'b0;
            s1_v_q    <= 1'b0;
            s1_last_q <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_last_q <= 1'b0;
        end else begin
            in_v_q    <= accept;
            in_last_q <= accept && last_beat;
            s1_v_q    <= in_v_q;
            s1_last_q <= in_last_q;
            s2_v_q    <= s1_v_q;
            s2_last_q <= s1_last_q;
        end
    end

    // Data path needs no reset: everything leaving the block is gated by the valid chain.
    always_ff @(posedge HCLK) begin
        in_r_q <= DATA_R_IN;
        in_g_q <= DATA_G_IN;
        in_b_q <= DATA_B_IN;
        s1_r_q <= in_r_q;
        s1_g_q <= in_g_q;
        s1_b_q <= in_b_q;
        s2_r_q <= s1_r_q;
        s2_g_q <= s1_g_q;
        s2_b_q <= s1_b_q;
        for (int k = 0; k < NUM_OF_PIXEL; k++) begin
            pr_q[k]   <= 16'(in_r_q[8*k +: 8]) * 16'd77;
            pg_q[k]   <= 16'(in_g_q[8*k +: 8]) * 16'd150;
            pb_q[k]   <= 16'(in_b_q[8*k +: 8]) * 16'd29;
            gray_q[k] <= gray_d[k];
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_OF_PIXEL; k++) begin
            sum_d[k]  = 18'(pr_q[k]) + 18'(pg_q[k]) + 18'(pb_q[k]);
            gray_d[k] = 8'(sum_d[k] >> 8);
        end
    end

    // Saturating add or subtract; bit 8 is the carry or borrow.
    function automatic logic [7:0] bright(input logic [7:0] ch, input logic [7:0] v,
                                          input logic sub);
        logic [8:0] t;
        t = sub ? ({1'b0, ch} - {1'b0, v}) : ({1'b0, ch} + {1'b0, v});
        if (t[8]) begin
            return sub ? 8'h00 : 8'hFF;
        end
        return t[7:0];
    endfunction

    always_comb begin
        res_r = '0;
        res_g = '0;
        res_b = '0;
        for (int k = 0; k < NUM_OF_PIXEL; k++) begin
            case (mode_q)
                2'b00: begin
                    res_r[8*k +: 8] = s2_r_q[8*k +: 8];
                    res_g[8*k +: 8] = s2_g_q[8*k +: 8];
                    res_b[8*k +: 8] = s2_b_q[8*k +: 8];
                end
                2'b01: begin
                    res_r[8*k +: 8] = gray_q[k];
                    res_g[8*k +: 8] = gray_q[k];
                    res_b[8*k +: 8] = gray_q[k];
                end
                2'b10: begin
                    res_r[8*k +: 8] = bright(s2_r_q[8*k +: 8], value_q, sign_q);
                    res_g[8*k +: 8] = bright(s2_g_q[8*k +: 8], value_q, sign_q);
                    res_b[8*k +: 8] = bright(s2_b_q[8*k +: 8], value_q, sign_q);
                end
                default: begin
                    res_r[8*k +: 8] = (gray_q[k] > value_q) ? 8'hFF : 8'h00;
                    res_g[8*k +: 8] = (gray_q[k] > value_q) ? 8'hFF : 8'h00;
                    res_b[8*k +: 8] = (gray_q[k] > value_q) ? 8'hFF : 8'h00;
                end
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HSYNC_OUT  <= 1'b0;
            DATA_R_OUT <= '0;
            DATA_G_OUT <= '0;
            DATA_B_OUT <= '0;
            frame_done <= 1'b0;
        end else if (s2_v_q) begin
            HSYNC_OUT  <= 1'b1;
            DATA_R_OUT <= res_r;
            DATA_G_OUT <= res_g;
            DATA_B_OUT <= res_b;
            frame_done <= s2_last_q;
        end else begin
            HSYNC_OUT  <= 1'b0;
            DATA_R_OUT <= '0;
            DATA_G_OUT <= '0;
            DATA_B_OUT <= '0;
            frame_done <= 1'b0;
        end
    end

endmodule
